siso_layer_scheduler: RTL and testbench
=======================================

// Module: siso_layer_scheduler
// PURPOSE
//  Read-side sequencer for the SISO row-unit. It walks address x layer x iteration and drives rdlayer/rdaddress/rden_LLR/rden_E into the row unit's *_regin ports.
//  It counts row-unit reads still in flight (issued minus wren returns) and signals frame completion once the pipeline has drained.
//  Sits between the decoder top-level control (start/done) and one SISO_rowunit.
// PARAMETERS
//  LAYERS      2   layers per iteration
//  ADDRWIDTH   5   address width (matches row unit)
//  ADDRDEPTH   20  words per layer, addresses 0..ADDRDEPTH-1
//  ITERBITS    4   width of max_iter / iter_count
//  HAZARD_GAP  0   idle cycles inserted between consecutive layers (0 = back-to-back)
//  OUTBITS     5   width of in-flight counter; 2**OUTBITS > row-unit latency (12)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous, active-high reset
//  start      in   1          begin a frame; sampled only in IDLE
//  max_iter   in   ITERBITS   iteration count; latched at start; 0 treated as 1
//  hold       in   1          stall: no issue this cycle, counters frozen
//  wren       in   1          row-unit write-back strobe (one per completed read)
//  rdlayer    out  1          layer select to row unit (LSB of layer index)
//  rdaddress  out  ADDRWIDTH  read address to row unit
//  rden_LLR   out  1          LLR read enable (registered)
//  rden_E     out  1          E-memory read enable; always equal to rden_LLR
//  iter_count out  ITERBITS   current iteration index, 0-based
//  busy       out  1          high from first issue cycle through the done cycle
//  done       out  1          one-cycle pulse when the frame is fully written back
// BEHAVIOUR
//  - All outputs are registered. On rst all outputs are 0, state=IDLE, in-flight=0.
//  - FSM states: IDLE, RUN, GAP, DRAIN.
//    IDLE : start=1 -> RUN; latch max_iter; addr=0, layer=0, iter=0.
//    RUN  : Each cycle with hold=0 issues one read (rden_*=1, current addr/layer), then advances addr.
//           With hold=1, rden_*=0 and nothing advances.
//           addr==ADDRDEPTH-1 wraps to 0 and layer++. layer==LAYERS-1 wraps to 0 and iter++.
//           After the final issue (iter==max_iter-1, last layer, last addr) -> DRAIN.
//           Otherwise on a layer wrap -> GAP if HAZARD_GAP>0.
//    GAP  : rden_*=0 for HAZARD_GAP cycles (hold freezes the gap counter) -> RUN.
//    DRAIN: rden_*=0; when in-flight==0 -> assert done 1 cycle -> IDLE.
//  - Timing: start sampled at cycle t -> first rden_LLR=1 at t+1 with addr 0, layer 0.
//  - in-flight counter: +1 per issued read, -1 per wren; both in the same cycle -> unchanged.
//    Saturation is never reached by construction (checked by assertion).
//  - busy=1 from t+1; busy falls together with done, i.e. busy=0 the cycle after done.
//  - start while busy is ignored. hold in IDLE/DRAIN has no effect.
//  - wren while in-flight==0 is a protocol error: counter stays 0, flagged by assertion.
//  - rst mid-frame: next cycle is IDLE, rden_*=0, busy=0, done=0.
//    Late wren pulses from the row unit after a reset are ignored (counter floors at 0).
//  - iter_count holds its final value after done until the next start.
// TESTING
//  1. Reset: rst=1 for 3 cycles, then rst=0 with start=0 -> all outputs stay 0.
//  2. Single iteration, default params, max_iter=1, hold=0, row-unit model wren = rden delayed 12 cycles.
//     -> addresses 0..19 layer 0, then 0..19 layer 1, cycles t+1..t+40; done at t+53.
//  3. max_iter=2 -> 80 issues, iter_count goes 0->1 at t+41, last issue at t+80, done at t+93.
//  4. hold pulses at addr 5 (2 cycles) and at the layer wrap (1 cycle) -> sequence continues with no skipped or repeated address; done delayed by 3 cycles.
//  5. HAZARD_GAP=3, max_iter=1 -> 3 idle cycles between addr 19/layer 0 and addr 0/layer 1; done at t+56.
//  6. rst asserted at t+25, mid-frame -> IDLE next cycle, outputs 0. Then start again -> clean restart at addr 0, layer 0, iter 0.
//     start=1 while busy -> ignored.

Source files
------------

// File: rtl/siso_layer_scheduler.sv
// Read-side sequencer for one SISO row unit: walks address x layer x iteration,
// tracks reads still in flight and pulses done once all write-backs have returned.
module siso_layer_scheduler #(
  parameter int LAYERS     = 2,
  parameter int ADDRWIDTH  = 5,
  parameter int ADDRDEPTH  = 20,
  parameter int ITERBITS   = 4,
  parameter int HAZARD_GAP = 0,
  parameter int OUTBITS    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 hold,
  input  logic                 wren,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 busy,
  output logic                 done
);

  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int GW = (HAZARD_GAP > 1) ? $clog2(HAZARD_GAP) : 1;

  typedef enum logic [1:0] {IDLE, RUN, GAP, DRAIN} state_t;

  state_t               state;
  logic [ADDRWIDTH-1:0] addr;
  logic [LW-1:0]        layer;
  logic [ITERBITS-1:0]  iter;
  logic [ITERBITS-1:0]  max_q;
  logic [GW-1:0]        gap_cnt;
  logic [OUTBITS-1:0]   inflight;

  logic issue, last_addr, last_layer, last_iter;

  always_comb begin
    issue      = (state == RUN) && !hold;
    last_addr  = (addr == ADDRWIDTH'(ADDRDEPTH - 1));
    last_layer = (layer == LW'(LAYERS - 1));
    last_iter  = (iter == max_q - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      layer      <= '0;
      iter       <= '0;
      max_q      <= '0;
      gap_cnt    <= '0;
      rdlayer    <= 1'b0;
      rdaddress  <= '0;
      rden_LLR   <= 1'b0;
      rden_E     <= 1'b0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rden_LLR <= 1'b0;
      rden_E   <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            state      <= RUN;
            max_q      <= (max_iter == '0) ? ITERBITS'(1) : max_iter;
            addr       <= '0;
            layer      <= '0;
            iter       <= '0;
            iter_count <= '0;
          end
        end
        RUN: begin
          busy <= 1'b1;
          if (issue) begin
            rden_LLR   <= 1'b1;
            rden_E     <= 1'b1;
            rdaddress  <= addr;
            rdlayer    <= layer[0];
            iter_count <= iter;
            if (last_addr) begin
              addr <= '0;
              // Every layer wrap except the final one may need a hazard gap.
              if (last_layer && last_iter) begin
                layer <= '0;
                state <= DRAIN;
              end else begin
                if (last_layer) begin
                  layer <= '0;
                  iter  <= iter + 1'b1;
                end else begin
                  layer <= layer + 1'b1;
                end
                if (HAZARD_GAP > 0) begin
                  state   <= GAP;
                  gap_cnt <= '0;
                end
              end
            end else begin
              addr <= addr + 1'b1;
            end
          end
        end
        GAP: begin
          if (!hold) begin
            if (gap_cnt == GW'((HAZARD_GAP > 0) ? HAZARD_GAP - 1 : 0))
              state <= RUN;
            else
              gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A stray wren with nothing outstanding is dropped so the count floors at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      assert (!(wren && !issue && inflight == '0))
        else $error("siso_layer_scheduler: wren with no read in flight");
      assert (!(issue && !wren && inflight == '1))
        else $error("siso_layer_scheduler: in-flight counter overflow");
      if (issue && !wren)
        inflight <= inflight + 1'b1;
      else if (!issue && wren && inflight != '0)
        inflight <= inflight - 1'b1;
    end
  end

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Directed bench for siso_layer_scheduler: scoreboard of expected reads plus
// cycle-exact done/busy/idle checks, with a 12-cycle row-unit write-back model.
module tb_siso_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] max_iter = '0;
  logic       hold = 1'b0;
  logic       wren0, wren1;

  logic       rdlayer0, rden_LLR0, rden_E0, busy0, done0;
  logic [4:0] rdaddress0;
  logic [3:0] iter_count0;
  logic       rdlayer1, rden_LLR1, rden_E1, busy1, done1;
  logic [4:0] rdaddress1;
  logic [3:0] iter_count1;

  logic [10:0] pipe0, pipe1;

  int n_checks = 0;
  int n_fail   = 0;
  logic sel = 1'b0;

  typedef struct packed {
    logic [3:0] it;
    logic       ly;
    logic [4:0] ad;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  siso_layer_scheduler dut (
    .clk(clk), .rst(rst), .start(start0), .max_iter(max_iter), .hold(hold),
    .wren(wren0), .rdlayer(rdlayer0), .rdaddress(rdaddress0),
    .rden_LLR(rden_LLR0), .rden_E(rden_E0), .iter_count(iter_count0),
    .busy(busy0), .done(done0)
  );

  siso_layer_scheduler #(.HAZARD_GAP(3)) dut_gap (
    .clk(clk), .rst(rst), .start(start1), .max_iter(max_iter), .hold(hold),
    .wren(wren1), .rdlayer(rdlayer1), .rdaddress(rdaddress1),
    .rden_LLR(rden_LLR1), .rden_E(rden_E1), .iter_count(iter_count1),
    .busy(busy1), .done(done1)
  );

  // Row-unit model: a read issued at edge n is written back (wren sampled) at edge n+12.
  always @(posedge clk) begin
    if (rst) begin
      pipe0 <= '0;
      pipe1 <= '0;
    end else begin
      pipe0 <= {pipe0[9:0], rden_LLR0};
      pipe1 <= {pipe1[9:0], rden_LLR1};
    end
  end
  assign wren0 = pipe0[10];
  assign wren1 = pipe1[10];

  logic       o_rden, o_rden_e, o_layer, o_busy, o_done;
  logic [4:0] o_addr;
  logic [3:0] o_iter;
  assign o_rden   = sel ? rden_LLR1   : rden_LLR0;
  assign o_rden_e = sel ? rden_E1     : rden_E0;
  assign o_layer  = sel ? rdlayer1    : rdlayer0;
  assign o_addr   = sel ? rdaddress1  : rdaddress0;
  assign o_iter   = sel ? iter_count1 : iter_count0;
  assign o_busy   = sel ? busy1       : busy0;
  assign o_done   = sel ? done1       : done0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rden_LLR"}, 32'(o_rden), 0);
    check({tag, " rden_E"}, 32'(o_rden_e), 0);
    check({tag, " busy"}, 32'(o_busy), 0);
    check({tag, " done"}, 32'(o_done), 0);
    check({tag, " rdaddress"}, 32'(o_addr), 0);
    check({tag, " rdlayer"}, 32'(o_layer), 0);
    check({tag, " iter_count"}, 32'(o_iter), 0);
  endtask

  // Runs one frame; k counts edges after the edge that sampled start (k=0).
  task automatic run_frame(input logic s, input int mi, input int done_k,
                           input int idle_lo, input int idle_hi,
                           input int hold_lo, input int hold_hi, input int hold_k2,
                           input int abort_k, input int restart_k, input string tag);
    int iters;
    exp_t e;
    bit in_hold, in_idle;
    sel = s;
    iters = (mi == 0) ? 1 : mi;
    q.delete();
    for (int it = 0; it < iters; it++)
      for (int ly = 0; ly < 2; ly++)
        for (int ad = 0; ad < 20; ad++)
          q.push_back('{it: 4'(it), ly: 1'(ly), ad: 5'(ad)});
    max_iter = 4'(mi);
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check({tag, " busy k0"}, 32'(o_busy), 0);
    check({tag, " rden k0"}, 32'(o_rden), 0);
    for (int k = 1; k <= done_k + 1; k++) begin
      in_hold = (k >= hold_lo && k <= hold_hi) || (k == hold_k2);
      in_idle = in_hold || (k >= idle_lo && k <= idle_hi);
      hold = in_hold;
      if (k == abort_k) rst = 1'b1;
      if (k == restart_k) begin
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      if (k == abort_k) begin
        check_all_zero({tag, " after mid-frame rst"});
        rst  = 1'b0;
        hold = 1'b0;
        q.delete();
        return;
      end
      check({tag, " rden_E==rden_LLR"}, 32'(o_rden_e), 32'(o_rden));
      if (o_rden === 1'b1) begin
        if (q.size() == 0) begin
          check({tag, " extra issue"}, 1, 0);
        end else begin
          e = q.pop_front();
          check({tag, " rdaddress"}, 32'(o_addr), 32'(e.ad));
          check({tag, " rdlayer"}, 32'(o_layer), 32'(e.ly));
          check({tag, " iter_count"}, 32'(o_iter), 32'(e.it));
        end
      end
      if (k == 1 && !in_idle) check({tag, " first issue at t+1"}, 32'(o_rden), 1);
      if (in_idle) check({tag, " idle cycle rden"}, 32'(o_rden), 0);
      check({tag, " done"}, 32'(o_done), 32'(k == done_k));
      check({tag, " busy"}, 32'(o_busy), 32'(k <= done_k));
    end
    hold = 1'b0;
    check({tag, " missing issues"}, 32'(q.size()), 0);
  endtask

  initial begin
    // Reset held for three cycles, then released with start low.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sel = 1'b0;
    check_all_zero("reset dut");
    sel = 1'b1;
    check_all_zero("reset dut_gap");

    run_frame(1'b0, 1, 53, 0, -1, 0, -1, 0, 0, 0, "single iter");
    run_frame(1'b0, 2, 93, 0, -1, 0, -1, 0, 0, 0, "two iter");
    run_frame(1'b0, 1, 56, 0, -1, 6, 7, 23, 0, 0, "hold");
    run_frame(1'b1, 1, 56, 21, 23, 0, -1, 0, 0, 0, "hazard gap");
    run_frame(1'b0, 0, 53, 0, -1, 0, -1, 0, 0, 0, "max_iter zero");
    run_frame(1'b0, 1, 53, 0, -1, 0, -1, 0, 25, 0, "abort");
    run_frame(1'b0, 1, 53, 0, -1, 0, -1, 0, 0, 10, "restart, start while busy");
    repeat (2) @(negedge clk);
    check("idle after frame busy", 32'(busy0), 0);
    check("iter_count held after done", 32'(iter_count0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
